mc_ctrl_fsm: RTL and testbench
==============================

// Module: mc_ctrl_fsm
// PURPOSE
//  Multi-cycle RV32I control FSM for the KLP32 datapath. Sequences fetch/decode/execute/mem/writeback.
//  Drives immgen imm_sel, ALU operand/op selects, regfile/PC/IR write strobes and the memory request handshake.
//  Sits between the instruction register, branch comparator and unified memory port; holds no data itself.
// PARAMETERS
//  IMM_SEL_W    3   width of imm_sel (matches immgen k)
//  MEM_TIMEOUT  15  max wait cycles for mem_ready per request; 0 = watchdog disabled
//  CNT_W        4   width of the wait counter; must hold MEM_TIMEOUT
// PORTS
//  clk        in   1   rising-edge clock
//  rst_n      in   1   asynchronous, active-low reset
//  instr      in   32  IR contents; valid from DECODE onward
//  mem_ready  in   1   memory completes request this cycle; ignored when mem_req=0
//  br_taken   in   1   branch comparator result for instr funct3; sampled in EXEC
//  ir_we      out  1   load IR from mem rdata
//  pc_we      out  1   load PC
//  pc_sel     out  2   00 PC+4, 01 ALUOut, 10 ALUOut&~1 (jalr)
//  addr_sel   out  1   mem address: 0 PC, 1 ALUOut
//  mem_req    out  1   memory request; held until mem_ready
//  mem_we     out  1   store
//  mem_size   out  2   instr[13:12] for loads/stores, else 10
//  imm_sel    out  IMM_SEL_W  000 I, 001 S, 010 B, 011 U, 100 J
//  alu_a_sel  out  2   00 rs1, 01 PC, 10 zero
//  alu_b_sel  out  1   0 rs2, 1 imm
//  alu_op     out  4   ALU operation code (package constants)
//  reg_we     out  1   regfile write
//  wb_sel     out  2   00 ALUOut, 01 mem rdata, 10 PC+4
//  illegal    out  1   sticky: illegal opcode trapped
//  bus_err    out  1   sticky: memory watchdog expired
//  halted     out  1   FSM in HALT
// BEHAVIOUR
//  States: BOOT, FETCH, DECODE, EXEC, MEM, WB, HALT. Reset -> BOOT; all outputs 0 while rst_n=0 and in BOOT.
//  BOOT->FETCH after 1 cycle. Outputs are Moore on state plus decode of registered instr (no instr->output path in FETCH).
//  FETCH: mem_req=1, addr_sel=0; on mem_ready: ir_we=1, ->DECODE. DECODE: imm_sel/selects valid, ->EXEC.
//  EXEC: ALU result registered into ALUOut. Branch: pc_we=1, pc_sel=br_taken?01:00, ->FETCH.
//    Load/store ->MEM; OP/OP-IMM/LUI/AUIPC/JAL/JALR ->WB; FENCE: pc_we=1 pc_sel=00 ->FETCH; SYSTEM ->HALT.
//  MEM: mem_req=1, addr_sel=1, mem_we=store. Load: on ready ->WB. Store: on ready pc_we=1 pc_sel=00 ->FETCH.
//  WB: reg_we=1 (rd=x0 still asserted; regfile drops it), pc_we=1; JAL pc_sel=01, JALR 10, else 00; ->FETCH.
//  Latency, zero-wait memory: branch 3, store/ALU/LUI/AUIPC/JAL/JALR 4, load 5 cycles.
//  Handshake: mem_req, addr_sel, mem_we, mem_size stable while waiting; ready on a cycle with mem_req=0 ignored.
//  Watchdog: counter clears on entry to FETCH/MEM, increments each waiting cycle; reaching MEM_TIMEOUT -> HALT, bus_err=1.
//  HALT: all strobes 0, halted=1, only reset exits. Reset mid-request drops mem_req asynchronously; request abandoned.
//  Never pc_we and reg_we in different instructions' cycles: exactly one pc_we pulse per retired instr.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined: unknown opcode in DECODE -> HALT, illegal=1.
//  Not defined: unknown opcode treated as NOP (DECODE: pc_we=1 pc_sel=00 ->FETCH); illegal tied 0.
// STRUCTURE
//  klp32_pkg: opcode constants, IMM_I..IMM_J encodings, ALU_* op codes, state enum, pc_sel/wb_sel/alu_a_sel codes.
//  Sub-module ctrl_decode (combinational): instr -> instr class, imm_sel, alu_op, alu_a/b_sel, legal flag.
//  mc_ctrl_fsm holds state register, wait counter, sticky flags and per-state output muxing.
// TESTING
//  Reset: rst_n=0 -> all outputs 0; release -> 1 BOOT cycle, then mem_req=1 addr_sel=0.
//  addi x1,x0,5 (0x00500093), ready=1 -> 4 cycles; imm_sel=000 alu_b_sel=1 ALU_ADD; WB reg_we=1 wb_sel=00 pc_sel=00.
//  sw x1,8(x2) (0x00112423), ready after 3 waits -> imm_sel=001; MEM mem_req/mem_we=1 mem_size=10 held 4 cycles; pc_we once, no reg_we.
//  beq x0,x0,-4 (0xFE000EE3): br_taken=1 -> imm_sel=010, EXEC pc_we=1 pc_sel=01, 3 cycles; br_taken=0 -> pc_sel=00.
//  jal x1,16 (0x010000EF) -> imm_sel=100, WB wb_sel=10 pc_sel=01; lui x0,0x12345 (0x12345037) -> imm_sel=011 alu_a_sel=10.
//  MEM_TIMEOUT=8, ready held 0 in FETCH -> bus_err=halted=1 after 8 waits; instr 0x0000007F: macro on -> illegal=1 halted, off -> pc_we, FETCH.

Source files
------------

// File: rtl/mc_ctrl_fsm_pkg.sv
// KLP32 multi-cycle control: shared encodings.
// Opcodes, select codes, ALU ops, state and class enums.
package mc_ctrl_fsm_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_ALU   = 2'b01;
  localparam logic [1:0] PC_JALR  = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] A_RS1  = 2'b00;
  localparam logic [1:0] A_PC   = 2'b01;
  localparam logic [1:0] A_ZERO = 2'b10;

  localparam logic B_RS2 = 1'b0;
  localparam logic B_IMM = 1'b1;

  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

  typedef enum logic [3:0] {
    CLS_ALU,
    CLS_JAL,
    CLS_JALR,
    CLS_BRANCH,
    CLS_LOAD,
    CLS_STORE,
    CLS_FENCE,
    CLS_SYSTEM,
    CLS_ILLEGAL
  } cls_t;

  typedef struct packed {
    cls_t       cls;
    logic [2:0] imm_sel;
    logic [3:0] alu_op;
    logic [1:0] alu_a_sel;
    logic       alu_b_sel;
    logic       legal;
  } dec_t;

  // funct7[5] only selects SUB for register ops, SRA for both
  function automatic logic [3:0] alu_op_of(
    input logic [2:0] f3,
    input logic       alt,
    input logic       is_reg
  );
    case (f3)
      3'b000:  return (alt && is_reg) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// KLP32 unified memory port handshake.
// Controller is master; memory answers with mem_ready.
interface mc_ctrl_fsm_if;

  logic       mem_req;
  logic       mem_ready;
  logic       mem_we;
  logic [1:0] mem_size;
  logic       addr_sel;

  modport master (
    output mem_req,
    output mem_we,
    output mem_size,
    output addr_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_size,
    input  addr_sel,
    output mem_ready
  );

endinterface

// File: rtl/mc_ctrl_fsm_decode.sv
// KLP32 instruction class / select decoder.
// Purely combinational; fed from the instruction register.
module mc_ctrl_fsm_decode
  import mc_ctrl_fsm_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output dec_t       dec
);

  // opcode -> class, immediate format and ALU operand/op selects
  always_comb begin
    dec.cls       = CLS_ILLEGAL;
    dec.imm_sel   = IMM_I;
    dec.alu_op    = ALU_ADD;
    dec.alu_a_sel = A_RS1;
    dec.alu_b_sel = B_IMM;
    dec.legal     = 1'b1;
    unique case (1'b1)
      opcode == OPC_OP: begin
        dec.cls       = CLS_ALU;
        dec.alu_b_sel = B_RS2;
        dec.alu_op    = alu_op_of(funct3, funct7_5, 1'b1);
      end
      opcode == OPC_OPIMM: begin
        dec.cls    = CLS_ALU;
        dec.alu_op = alu_op_of(funct3, funct7_5, 1'b0);
      end
      opcode == OPC_LUI: begin
        dec.cls       = CLS_ALU;
        dec.imm_sel   = IMM_U;
        dec.alu_a_sel = A_ZERO;
      end
      opcode == OPC_AUIPC: begin
        dec.cls       = CLS_ALU;
        dec.imm_sel   = IMM_U;
        dec.alu_a_sel = A_PC;
      end
      opcode == OPC_JAL: begin
        dec.cls       = CLS_JAL;
        dec.imm_sel   = IMM_J;
        dec.alu_a_sel = A_PC;
      end
      opcode == OPC_JALR: begin
        dec.cls = CLS_JALR;
      end
      opcode == OPC_BRANCH: begin
        dec.cls       = CLS_BRANCH;
        dec.imm_sel   = IMM_B;
        dec.alu_a_sel = A_PC;
      end
      opcode == OPC_LOAD: begin
        dec.cls = CLS_LOAD;
      end
      opcode == OPC_STORE: begin
        dec.cls     = CLS_STORE;
        dec.imm_sel = IMM_S;
      end
      opcode == OPC_FENCE: begin
        dec.cls = CLS_FENCE;
      end
      opcode == OPC_SYSTEM: begin
        dec.cls = CLS_SYSTEM;
      end
      default: begin
        dec.legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// KLP32 multi-cycle control FSM (fetch/decode/exec/mem/wb).
// Optional ILLEGAL_TRAP_EN: unknown opcodes halt instead of NOP.
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int IMM_SEL_W   = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mc_ctrl_fsm_if.master        mem,
  input  logic [31:0]          instr,
  input  logic                 br_taken,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic [1:0]           pc_sel,
  output logic [IMM_SEL_W-1:0] imm_sel,
  output logic [1:0]           alu_a_sel,
  output logic                 alu_b_sel,
  output logic [3:0]           alu_op,
  output logic                 reg_we,
  output logic [1:0]           wb_sel,
  output logic                 illegal,
  output logic                 bus_err,
  output logic                 halted
);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             bus_err_q;
  dec_t             dec;
  logic             ready;
  logic             is_load;
  logic             is_store;
  logic             wd_expire;
  logic             req;
  logic             we;
  logic [1:0]       size;
  logic             asel;
  logic             unused_instr;

  mc_ctrl_fsm_decode u_decode (
    .opcode   (instr[6:0]),
    .funct3   (instr[14:12]),
    .funct7_5 (instr[30]),
    .dec      (dec)
  );

  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  assign ready    = mem.mem_ready;
  assign is_load  = (dec.cls == CLS_LOAD);
  assign is_store = (dec.cls == CLS_STORE);

  // last permitted wait cycle; MEM_TIMEOUT of 0 never expires
  assign wd_expire = (MEM_TIMEOUT != 0) &&
                     (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  assign bus_err = bus_err_q;
  assign halted  = (state == ST_HALT);

  assign mem.mem_req  = req;
  assign mem.mem_we   = we;
  assign mem.mem_size = size;
  assign mem.addr_sel = asel;

  // state register, memory watchdog and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_BOOT;
      wait_cnt  <= '0;
      bus_err_q <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      wait_cnt <= '0;
      unique case (state)
        ST_BOOT: state <= ST_FETCH;
        ST_FETCH: begin
          if (ready) begin
            state <= ST_DECODE;
          end else if (wd_expire) begin
            state     <= ST_HALT;
            bus_err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ST_DECODE: begin
          if (dec.legal) begin
            state <= ST_EXEC;
          end else begin
`ifdef ILLEGAL_TRAP_EN
            state     <= ST_HALT;
            illegal_q <= 1'b1;
`else
            state <= ST_FETCH;
`endif
          end
        end
        ST_EXEC: begin
          unique case (dec.cls)
            CLS_BRANCH, CLS_FENCE: state <= ST_FETCH;
            CLS_LOAD, CLS_STORE:   state <= ST_MEM;
            CLS_SYSTEM:            state <= ST_HALT;
            default:               state <= ST_WB;
          endcase
        end
        ST_MEM: begin
          if (ready) begin
            state <= is_store ? ST_FETCH : ST_WB;
          end else if (wd_expire) begin
            state     <= ST_HALT;
            bus_err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ST_WB:   state <= ST_FETCH;
        ST_HALT: state <= ST_HALT;
        default: state <= ST_BOOT;
      endcase
    end
  end

  // per-state strobes and selects; FETCH never looks at instr
  always_comb begin
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    req       = 1'b0;
    asel      = 1'b0;
    we        = 1'b0;
    size      = 2'b00;
    imm_sel   = '0;
    alu_a_sel = A_RS1;
    alu_b_sel = B_RS2;
    alu_op    = ALU_ADD;
    reg_we    = 1'b0;
    wb_sel    = WB_ALU;
    if (state inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB}) begin
      imm_sel   = IMM_SEL_W'(dec.imm_sel);
      alu_a_sel = dec.alu_a_sel;
      alu_b_sel = dec.alu_b_sel;
      alu_op    = dec.alu_op;
      size      = (is_load || is_store) ? instr[13:12] : SIZE_WORD;
    end
    unique case (state)
      ST_FETCH: begin
        req   = 1'b1;
        size  = SIZE_WORD;
        ir_we = ready;
      end
      ST_DECODE: begin
`ifndef ILLEGAL_TRAP_EN
        pc_we = !dec.legal;
`endif
      end
      ST_EXEC: begin
        if (dec.cls == CLS_BRANCH) begin
          pc_we  = 1'b1;
          pc_sel = br_taken ? PC_ALU : PC_PLUS4;
        end else if (dec.cls == CLS_FENCE) begin
          pc_we = 1'b1;
        end
      end
      ST_MEM: begin
        req   = 1'b1;
        asel  = 1'b1;
        we    = is_store;
        pc_we = is_store && ready;
      end
      ST_WB: begin
        reg_we = 1'b1;
        pc_we  = 1'b1;
        if (dec.cls == CLS_JAL) begin
          pc_sel = PC_ALU;
          wb_sel = WB_PC4;
        end else if (dec.cls == CLS_JALR) begin
          pc_sel = PC_JALR;
          wb_sel = WB_PC4;
        end else if (is_load) begin
          wb_sel = WB_MEM;
        end
      end
      ST_HALT: size = SIZE_WORD;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm.
// Build with or without ILLEGAL_TRAP_EN.
module tb_mc_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        br_taken = 1'b0;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic [2:0]  imm_sel;
  logic [1:0]  alu_a_sel;
  logic        alu_b_sel;
  logic [3:0]  alu_op;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic        illegal;
  logic        bus_err;
  logic        halted;

  int n_vec = 0;
  int n_err = 0;

  mc_ctrl_fsm_if mif();

  always #5 clk = ~clk;

  mc_ctrl_fsm #(
    .IMM_SEL_W   (3),
    .MEM_TIMEOUT (8),
    .CNT_W       (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem       (mif),
    .instr     (instr),
    .br_taken  (br_taken),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_sel    (pc_sel),
    .imm_sel   (imm_sel),
    .alu_a_sel (alu_a_sel),
    .alu_b_sel (alu_b_sel),
    .alu_op    (alu_op),
    .reg_we    (reg_we),
    .wb_sel    (wb_sel),
    .illegal   (illegal),
    .bus_err   (bus_err),
    .halted    (halted)
  );

  logic [24:0] outs;
  logic [9:0]  dec_o;
  logic [5:0]  wb_o;
  logic [4:0]  mem_o;

  assign outs = {ir_we, pc_we, pc_sel, mif.addr_sel, mif.mem_req,
                 mif.mem_we, mif.mem_size, imm_sel, alu_a_sel,
                 alu_b_sel, alu_op, reg_we, wb_sel, illegal,
                 bus_err, halted};
  assign dec_o = {imm_sel, alu_a_sel, alu_b_sel, alu_op};
  assign wb_o  = {reg_we, pc_we, wb_sel, pc_sel};
  assign mem_o = {mif.mem_req, mif.mem_we, mif.addr_sel, mif.mem_size};

  typedef struct {
    logic [31:0] ins;
    logic [9:0]  dec;
    logic [5:0]  wb;
    string       name;
  } vec_t;

  task automatic step(input logic rdy, input logic br);
    @(negedge clk);
    mif.mem_ready = rdy;
    br_taken      = br;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mif.mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    instr = 32'h0000007F;
    step(1'b1, 1'b1);
    n_vec++;
    if (outs !== '0) begin
      n_err++;
      $display("FAIL reset_outs: got %h want 0", outs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (outs !== '0) begin
      n_err++;
      $display("FAIL boot_outs: got %h want 0", outs);
    end
    step(1'b0, 1'b0);
    n_vec++;
    if ({mif.mem_req, mif.addr_sel, ir_we, halted} !== 4'b1000) begin
      n_err++;
      $display("FAIL boot_fetch: req/asel/irwe/halt=%b want 1000",
               {mif.mem_req, mif.addr_sel, ir_we, halted});
    end
  endtask

  task automatic test_alu_wb();
    vec_t tbl [7];
    tbl[0] = '{32'h00500093, 10'b000_00_1_0000, 6'b11_00_00, "addi"};
    tbl[1] = '{32'h12345037, 10'b011_10_1_0000, 6'b11_00_00, "lui"};
    tbl[2] = '{32'h010000EF, 10'b100_01_1_0000, 6'b11_10_01, "jal"};
    tbl[3] = '{32'h00001297, 10'b011_01_1_0000, 6'b11_00_00, "auipc"};
    tbl[4] = '{32'h000280E7, 10'b000_00_1_0000, 6'b11_10_10, "jalr"};
    tbl[5] = '{32'h402081B3, 10'b000_00_0_0001, 6'b11_00_00, "sub"};
    tbl[6] = '{32'h4030D213, 10'b000_00_1_0111, 6'b11_00_00, "srai"};
    for (int i = 0; i < 7; i++) begin
      instr = tbl[i].ins;
      step(1'b1, 1'b0);
      n_vec++;
      if ({ir_we, mif.mem_req, mif.addr_sel, dec_o} !== 13'b110_0000000000) begin
        n_err++;
        $display("FAIL %s_fetch: got %b want 1100000000000",
                 tbl[i].name, {ir_we, mif.mem_req, mif.addr_sel, dec_o});
      end
      step(1'b0, 1'b0);
      n_vec++;
      if ({dec_o, pc_we, reg_we, mif.mem_req} !== {tbl[i].dec, 3'b000}) begin
        n_err++;
        $display("FAIL %s_decode: got %b want %b", tbl[i].name,
                 {dec_o, pc_we, reg_we, mif.mem_req}, {tbl[i].dec, 3'b000});
      end
      step(1'b0, 1'b0);
      n_vec++;
      if ({pc_we, reg_we, mif.mem_req} !== 3'b000) begin
        n_err++;
        $display("FAIL %s_exec: pcwe/regwe/req=%b want 000",
                 tbl[i].name, {pc_we, reg_we, mif.mem_req});
      end
      step(1'b0, 1'b0);
      n_vec++;
      if (wb_o !== tbl[i].wb) begin
        n_err++;
        $display("FAIL %s_wb: got %b want %b", tbl[i].name, wb_o, tbl[i].wb);
      end
      step(1'b0, 1'b0);
      n_vec++;
      if ({mif.mem_req, mif.addr_sel, pc_we, reg_we} !== 4'b1000) begin
        n_err++;
        $display("FAIL %s_next_fetch: got %b want 1000", tbl[i].name,
                 {mif.mem_req, mif.addr_sel, pc_we, reg_we});
      end
    end
  endtask

  task automatic test_store();
    int pcw = 0;
    int rgw = 0;
    instr = 32'h00112423;
    step(1'b1, 1'b0);
    pcw += int'(pc_we);
    step(1'b0, 1'b0);
    pcw += int'(pc_we);
    n_vec++;
    if (dec_o !== 10'b001_00_1_0000) begin
      n_err++;
      $display("FAIL sw_decode: got %b want 0010010000", dec_o);
    end
    step(1'b0, 1'b0);
    pcw += int'(pc_we);
    rgw += int'(reg_we);
    for (int i = 0; i < 4; i++) begin
      step(i == 3, 1'b0);
      n_vec++;
      if ({mem_o, pc_we} !== {5'b11110, i == 3}) begin
        n_err++;
        $display("FAIL sw_mem%0d: req/we/asel/size/pcwe=%b want %b",
                 i, {mem_o, pc_we}, {5'b11110, i == 3});
      end
      pcw += int'(pc_we);
      rgw += int'(reg_we);
    end
    step(1'b0, 1'b0);
    n_vec++;
    if ({mif.mem_req, mif.addr_sel, mif.mem_we} !== 3'b100) begin
      n_err++;
      $display("FAIL sw_next_fetch: got %b want 100",
               {mif.mem_req, mif.addr_sel, mif.mem_we});
    end
    n_vec++;
    if (pcw != 1 || rgw != 0) begin
      n_err++;
      $display("FAIL sw_strobes: pc_we x%0d reg_we x%0d want 1 and 0", pcw, rgw);
    end
  endtask

  task automatic test_load();
    instr = 32'h0040A183;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    n_vec++;
    if (dec_o !== 10'b000_00_1_0000) begin
      n_err++;
      $display("FAIL lw_decode: got %b want 0000010000", dec_o);
    end
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    n_vec++;
    if ({mem_o, pc_we, reg_we} !== 7'b10110_00) begin
      n_err++;
      $display("FAIL lw_mem: got %b want 1011000", {mem_o, pc_we, reg_we});
    end
    step(1'b0, 1'b0);
    n_vec++;
    if (wb_o !== 6'b11_01_00) begin
      n_err++;
      $display("FAIL lw_wb: got %b want 110100", wb_o);
    end
    step(1'b0, 1'b0);
    n_vec++;
    if ({mif.mem_req, mif.addr_sel} !== 2'b10) begin
      n_err++;
      $display("FAIL lw_next_fetch: got %b want 10", {mif.mem_req, mif.addr_sel});
    end
  endtask

  task automatic test_branch();
    for (int t = 1; t >= 0; t--) begin
      instr = 32'hFE000EE3;
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      n_vec++;
      if ({dec_o, pc_we} !== {10'b010_01_1_0000, 1'b0}) begin
        n_err++;
        $display("FAIL beq%0d_decode: got %b want 01001100000", t, {dec_o, pc_we});
      end
      step(1'b0, t[0]);
      n_vec++;
      if ({pc_we, pc_sel, reg_we, mif.mem_req} !== {1'b1, 1'b0, t[0], 2'b00}) begin
        n_err++;
        $display("FAIL beq%0d_exec: pcwe/sel/regwe/req=%b want %b", t,
                 {pc_we, pc_sel, reg_we, mif.mem_req}, {1'b1, 1'b0, t[0], 2'b00});
      end
      step(1'b0, 1'b0);
      n_vec++;
      if ({mif.mem_req, mif.addr_sel, pc_we} !== 3'b100) begin
        n_err++;
        $display("FAIL beq%0d_next_fetch: got %b want 100", t,
                 {mif.mem_req, mif.addr_sel, pc_we});
      end
    end
  endtask

  task automatic test_illegal();
    instr = 32'h0000007F;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
`ifdef ILLEGAL_TRAP_EN
    n_vec++;
    if ({pc_we, halted, illegal} !== 3'b000) begin
      n_err++;
      $display("FAIL ill_decode: pcwe/halt/ill=%b want 000", {pc_we, halted, illegal});
    end
    step(1'b1, 1'b0);
    n_vec++;
    if ({halted, illegal, mif.mem_req, pc_we, ir_we} !== 5'b11000) begin
      n_err++;
      $display("FAIL ill_halt: got %b want 11000",
               {halted, illegal, mif.mem_req, pc_we, ir_we});
    end
`else
    n_vec++;
    if ({pc_we, pc_sel, halted, illegal} !== 5'b10000) begin
      n_err++;
      $display("FAIL ill_nop: pcwe/sel/halt/ill=%b want 10000",
               {pc_we, pc_sel, halted, illegal});
    end
    step(1'b0, 1'b0);
    n_vec++;
    if ({mif.mem_req, mif.addr_sel, halted, illegal} !== 4'b1000) begin
      n_err++;
      $display("FAIL ill_next_fetch: got %b want 1000",
               {mif.mem_req, mif.addr_sel, halted, illegal});
    end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1'b0, 1'b0);
    n_vec++;
    if (mif.mem_req !== 1'b1) begin
      n_err++;
      $display("FAIL mid_req_before: got %b want 1", mif.mem_req);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (outs !== '0) begin
      n_err++;
      $display("FAIL mid_async_drop: got %h want 0", outs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0);
    n_vec++;
    if ({mif.mem_req, mif.addr_sel, halted} !== 3'b100) begin
      n_err++;
      $display("FAIL mid_refetch: got %b want 100", {mif.mem_req, mif.addr_sel, halted});
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    for (int i = 2; i <= 8; i++) begin
      step(1'b0, 1'b0);
      n_vec++;
      if ({mif.mem_req, halted, bus_err} !== 3'b100) begin
        n_err++;
        $display("FAIL wd_wait%0d: req/halt/berr=%b want 100", i,
                 {mif.mem_req, halted, bus_err});
      end
    end
    step(1'b1, 1'b0);
    n_vec++;
    if ({halted, bus_err, mif.mem_req, ir_we, pc_we, reg_we} !== 6'b110000) begin
      n_err++;
      $display("FAIL wd_halt: got %b want 110000",
               {halted, bus_err, mif.mem_req, ir_we, pc_we, reg_we});
    end
    step(1'b1, 1'b0);
    n_vec++;
    if ({halted, bus_err, mif.mem_req} !== 3'b110) begin
      n_err++;
      $display("FAIL wd_stays: got %b want 110", {halted, bus_err, mif.mem_req});
    end
  endtask

  initial begin
    mif.mem_ready = 1'b0;
    test_reset();
    test_alu_wb();
    test_store();
    test_load();
    test_branch();
    test_illegal();
    test_reset_mid();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
